// File: rtl/serializador_pkg.sv
// rtl/serializador_pkg.sv - shared types and index helpers for the block serializer
// Readout direction is selected by SERIALIZADOR_REVERSE_EN (descending when defined).
package serializador_pkg;

    typedef enum logic {IDLE, DRAIN} state_t;

`ifdef SERIALIZADOR_REVERSE_EN
    localparam bit READ_DOWN = 1'b1;
`else
    localparam bit READ_DOWN = 1'b0;
`endif

    function automatic int idx_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int start_index(input int m);
        return READ_DOWN ? m - 1 : 0;
    endfunction

    function automatic int end_index(input int m);
        return READ_DOWN ? 0 : m - 1;
    endfunction

endpackage

// File: rtl/serializador_contador.sv
// rtl/serializador_contador.sv - block index counter with load-to-start, step and end flag
module serializador_contador #(
    parameter int         W      = 4,
    parameter logic [W-1:0] START  = '0,
    parameter logic [W-1:0] FINISH = '1,
    parameter bit         DOWN   = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] cnt,
    output logic         at_end
);

    assign at_end = (cnt == FINISH);

    // Wrapping from the end index back to START keeps the count inside 0..M-1
    // even when M is not a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= START;
        end else if (step) begin
            if (at_end) begin
                cnt <= START;
            end else if (DOWN) begin
                cnt <= cnt - W'(1);
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/bloque_serializador.sv
// rtl/bloque_serializador.sv - parallel-in serial-out block unloader (SERIALIZADOR_REVERSE_EN: descending readout)
module bloque_serializador
    import serializador_pkg::*;
#(
    parameter  int N     = 16,
    parameter  int M     = 16,
    localparam int IDX_W = idx_width(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [N-1:0]     load_data [M],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last
);

    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(start_index(M));
    localparam logic [IDX_W-1:0] END_IDX   = IDX_W'(end_index(M));

    state_t           state;
    state_t           next_state;
    logic [N-1:0]     bank [M];
    logic [IDX_W-1:0] cnt;
    logic             at_end;
    logic             draining;
    logic             consume;
    logic             load_fire;

    assign draining  = (state == DRAIN);
    assign consume   = draining && out_ready;
    // A new block may only land on the handshake of the final word, so no bubble appears.
    assign load_ready = rst && (!draining || (consume && at_end));
    assign load_fire  = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (load_fire) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (consume && at_end) begin
                    next_state = load_fire ? DRAIN : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < M; i++) begin
                bank[i] <= '0;
            end
        end else if (load_fire) begin
            for (int i = 0; i < M; i++) begin
                bank[i] <= load_data[i];
            end
        end
    end

    serializador_contador #(
        .W      (IDX_W),
        .START  (START_IDX),
        .FINISH (END_IDX),
        .DOWN   (READ_DOWN)
    ) u_contador (
        .clk    (clk),
        .rst    (rst),
        .load   (load_fire),
        .step   (consume),
        .cnt    (cnt),
        .at_end (at_end)
    );

    assign out_valid = draining;
    assign out_data  = draining ? bank[cnt] : '0;
    assign out_index = draining ? cnt : '0;
    assign out_last  = draining && at_end;

endmodule

// File: tb/tb_bloque_serializador.sv
// tb/tb_bloque_serializador.sv - scoreboard bench for bloque_serializador (N=16, M=4)
module tb_bloque_serializador;

    localparam int N = 16;
    localparam int M = 4;

    typedef struct packed {
        logic [N-1:0] data;
        logic [1:0]   idx;
        logic         last;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] load_data [M];
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   out_index;
    logic         out_last;

    exp_t q[$];
    int   checks;
    int   errors;
    logic last_rst;

    bloque_serializador #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_block(input logic [N-1:0] base);
        for (int i = 0; i < M; i++) begin
            load_data[i] = base + N'(i);
        end
    endtask

    task automatic push_block();
        int j;
        for (int i = 0; i < M; i++) begin
`ifdef SERIALIZADOR_REVERSE_EN
            j = M - 1 - i;
`else
            j = i;
`endif
            q.push_back('{data: load_data[j], idx: 2'(j), last: (i == M - 1)});
        end
    endtask

    // Compare one cycle at the negedge, then advance across the next rising edge.
    task automatic step();
        logic ev;
        logic lr_exp;
        exp_t f;
        @(negedge clk);
        if (!last_rst) begin
            q.delete();
            ev = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_index", out_index, 0);
            chk("rst_out_last", out_last, 0);
        end else begin
            ev = (q.size() != 0);
            chk("out_valid", out_valid, ev);
        end
        lr_exp = rst && (!ev || (out_ready && q[0].last));
        chk("load_ready", load_ready, lr_exp);
        if (ev) begin
            f = q[0];
            chk("out_data", out_data, f.data);
            chk("out_index", out_index, f.idx);
            chk("out_last", out_last, f.last);
            if (out_ready && rst) begin
                void'(q.pop_front());
            end
        end
        if (load_valid && lr_exp) begin
            push_block();
        end
        @(posedge clk);
        last_rst = rst;
        #1;
    endtask

    initial begin
        automatic bit bp_pattern [7] = '{1, 0, 0, 1, 1, 0, 1};
        checks     = 0;
        errors     = 0;
        last_rst   = 1'b0;
        rst        = 1'b0;
        load_valid = 1'b1;
        out_ready  = 1'b1;
        set_block(16'h5550);

        // reset held with a pending load
        repeat (3) step();
        rst        = 1'b1;
        load_valid = 1'b0;
        repeat (3) step();

        // basic drain
        set_block(16'h0001);
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (M + 2) step();

        // backpressure
        set_block(16'h0001);
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        foreach (bp_pattern[i]) begin
            out_ready = bp_pattern[i];
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) step();
        step();

        // back-to-back with load_valid held high throughout
        set_block(16'h0001);
        load_valid = 1'b1;
        step();
        set_block(16'h00A0);
        repeat (M) step();
        load_valid = 1'b0;
        repeat (M + 2) step();

        // reset in the middle of a drain
        set_block(16'h0001);
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (2) step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
        repeat (M + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
